// File: rtl/sm83_mem_ctrl_if.sv
// CPU-side bus of the SM83 memory controller: request qualifiers, address/data and
// the ready/data_oe handshake back to the core.
interface sm83_mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              mem_cs;
  logic              mem_oe;
  logic              mem_we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              data_oe;
  logic              ready;

  modport master (
    output mem_cs, mem_oe, mem_we, addr, wdata,
    input  rdata, data_oe, ready
  );

  modport slave (
    input  mem_cs, mem_oe, mem_we, addr, wdata,
    output rdata, data_oe, ready
  );
endinterface

// File: rtl/sm83_mem_ctrl.sv
// SM83 memory-side controller: registered region decode, read-latency sequencer and
// WRAM write path. Define SM83_BOOT_OVERLAY_EN to enable the sticky boot-ROM overlay disable.
module sm83_mem_ctrl #(
  parameter int                ADDR_W        = 16,
  parameter int                DATA_W        = 8,
  parameter logic [ADDR_W-1:0] ROM_BASE      = 16'h0000,
  parameter int                ROM_AW        = 8,
  parameter logic [ADDR_W-1:0] WRAM_BASE     = 16'hC000,
  parameter int                WRAM_AW       = 13,
  parameter int                READ_LAT      = 1,
  parameter logic [ADDR_W-1:0] BOOT_DIS_ADDR = 16'hFF50,
  parameter logic [DATA_W-1:0] UNMAP_DATA    = 8'hFF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sm83_mem_ctrl_if.slave     bus,
  output logic               o_rom_en,
  output logic [ROM_AW-1:0]  o_rom_addr,
  input  logic [DATA_W-1:0]  i_rom_dout,
  output logic               o_wram_en,
  output logic               o_wram_we,
  output logic [WRAM_AW-1:0] o_wram_addr,
  output logic [DATA_W-1:0]  o_wram_din,
  input  logic [DATA_W-1:0]  i_wram_dout,
  output logic               o_boot_done
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_DONE, S_WR} state_t;
  typedef enum logic [1:0] {RG_ROM, RG_WRAM, RG_BOOT, RG_UNMAP} region_t;

`ifdef SM83_BOOT_OVERLAY_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif
  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  state_t              r_state, w_state_nxt;
  region_t             r_region, w_region_nxt, w_region_dec;
  logic [1:0]          r_cnt, w_cnt_nxt;
  logic                w_req;
  logic [ADDR_W-1:0]   w_rom_off, w_wram_off;
  logic                w_rom_hit, w_wram_hit, w_boot_hit, w_boot_done;
  logic [DATA_W-1:0]   w_rd_sel;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_data_oe, r_ready;
  logic                r_rom_en, r_wram_en, r_wram_we;
  logic [ROM_AW-1:0]   r_rom_addr;
  logic [WRAM_AW-1:0]  r_wram_addr;
  logic [DATA_W-1:0]   r_wdata;

  assign w_req      = bus.mem_cs & (bus.mem_oe | bus.mem_we);
  assign w_rom_off  = bus.addr - ROM_BASE;
  assign w_wram_off = bus.addr - WRAM_BASE;
  assign w_rom_hit  = ((w_rom_off >> ROM_AW) == '0) && !w_boot_done;
  assign w_wram_hit = (w_wram_off >> WRAM_AW) == '0;
  assign w_boot_hit = BOOT_EN && (bus.addr == BOOT_DIS_ADDR);

  always_comb begin
    w_region_dec = RG_UNMAP;
    if (w_rom_hit)       w_region_dec = RG_ROM;
    else if (w_wram_hit) w_region_dec = RG_WRAM;
    else if (w_boot_hit) w_region_dec = RG_BOOT;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_region <= RG_UNMAP;
      r_cnt    <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_region <= w_region_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Write wins over read when both qualifiers are raised together.
  always_comb begin
    w_state_nxt  = r_state;
    w_region_nxt = r_region;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_region_nxt = w_region_dec;
          w_cnt_nxt    = 2'd0;
          w_state_nxt  = bus.mem_we ? S_WR : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == LAT_LAST) w_state_nxt = S_RD_DONE;
        else                   w_cnt_nxt   = r_cnt + 2'd1;
      end
      S_RD_DONE: w_state_nxt = S_IDLE;
      S_WR:      w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_sel = UNMAP_DATA;
    case (r_region)
      RG_ROM:  w_rd_sel = i_rom_dout;
      RG_WRAM: w_rd_sel = i_wram_dout;
      RG_BOOT: w_rd_sel = {{(DATA_W-1){1'b1}}, w_boot_done};
      default: w_rd_sel = UNMAP_DATA;
    endcase
  end

  // Outputs are derived from the next state so they line up with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata     <= '0;
      r_data_oe   <= 1'b0;
      r_ready     <= 1'b0;
      r_rom_en    <= 1'b0;
      r_wram_en   <= 1'b0;
      r_wram_we   <= 1'b0;
      r_rom_addr  <= '0;
      r_wram_addr <= '0;
      r_wdata     <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_rom_addr  <= w_rom_off[ROM_AW-1:0];
        r_wram_addr <= w_wram_off[WRAM_AW-1:0];
        r_wdata     <= bus.wdata;
      end
      if (r_state == S_RD_WAIT && w_state_nxt == S_RD_DONE) r_rdata <= w_rd_sel;
      r_rom_en  <= (w_state_nxt == S_RD_WAIT) && (w_region_nxt == RG_ROM);
      r_wram_en <= ((w_state_nxt == S_RD_WAIT) || (w_state_nxt == S_WR)) && (w_region_nxt == RG_WRAM);
      r_wram_we <= (w_state_nxt == S_WR) && (w_region_nxt == RG_WRAM);
      r_ready   <= (w_state_nxt == S_RD_DONE) || (w_state_nxt == S_WR);
      r_data_oe <= (w_state_nxt == S_RD_DONE);
    end
  end

`ifdef SM83_BOOT_OVERLAY_EN
  logic r_boot_done;

  // Sticky: committed only when the write cycle completes, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_boot_done <= 1'b0;
    else if (r_state == S_WR && r_region == RG_BOOT && r_wdata != '0)
      r_boot_done <= 1'b1;
  end

  assign w_boot_done = r_boot_done;
`else
  assign w_boot_done = 1'b0;
`endif

  assign bus.rdata   = r_rdata;
  assign bus.data_oe = r_data_oe;
  assign bus.ready   = r_ready;
  assign o_rom_en    = r_rom_en;
  assign o_rom_addr  = r_rom_addr;
  assign o_wram_en   = r_wram_en;
  assign o_wram_we   = r_wram_we;
  assign o_wram_addr = r_wram_addr;
  assign o_wram_din  = r_wdata;
  assign o_boot_done = w_boot_done;

endmodule

// File: tb/tb_sm83_mem_ctrl.sv
// Directed bench for sm83_mem_ctrl: one instance with READ_LAT=1 and one with READ_LAT=2,
// sharing the request lines, each with its own ROM/WRAM model.
module tb_sm83_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        reqCs, reqOe, reqWe, selB;
  logic [15:0] reqAddr;
  logic [7:0]  reqWdata;

  sm83_mem_ctrl_if #(.ADDR_W(16), .DATA_W(8)) busA ();
  sm83_mem_ctrl_if #(.ADDR_W(16), .DATA_W(8)) busB ();

  assign busA.mem_cs = reqCs & ~selB;
  assign busB.mem_cs = reqCs & selB;
  assign busA.mem_oe = reqOe;
  assign busB.mem_oe = reqOe;
  assign busA.mem_we = reqWe;
  assign busB.mem_we = reqWe;
  assign busA.addr   = reqAddr;
  assign busB.addr   = reqAddr;
  assign busA.wdata  = reqWdata;
  assign busB.wdata  = reqWdata;

  logic        romEnA, romEnB, wramEnA, wramEnB, wramWeA, wramWeB, bootDoneA, bootDoneB;
  logic [7:0]  romAddrA, romAddrB, romDoutA, romDoutB;
  logic [12:0] wramAddrA, wramAddrB;
  logic [7:0]  wramDinA, wramDinB, wramDoutA, wramDoutB;

  logic [7:0] romMem [256];
  logic [7:0] wramMemA [8192];
  logic [7:0] wramMemB [8192];

  assign romDoutA  = romMem[romAddrA];
  assign romDoutB  = romMem[romAddrB];
  assign wramDoutA = wramMemA[wramAddrA];
  assign wramDoutB = wramMemB[wramAddrB];

  always @(posedge clk) begin
    if (wramWeA) wramMemA[wramAddrA] <= wramDinA;
    if (wramWeB) wramMemB[wramAddrB] <= wramDinB;
  end

  sm83_mem_ctrl #(.READ_LAT(1)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .bus(busA),
    .o_rom_en(romEnA), .o_rom_addr(romAddrA), .i_rom_dout(romDoutA),
    .o_wram_en(wramEnA), .o_wram_we(wramWeA), .o_wram_addr(wramAddrA),
    .o_wram_din(wramDinA), .i_wram_dout(wramDoutA), .o_boot_done(bootDoneA)
  );

  sm83_mem_ctrl #(.READ_LAT(2)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .bus(busB),
    .o_rom_en(romEnB), .o_rom_addr(romAddrB), .i_rom_dout(romDoutB),
    .o_wram_en(wramEnB), .o_wram_we(wramWeB), .o_wram_addr(wramAddrB),
    .o_wram_din(wramDinB), .i_wram_dout(wramDoutB), .o_boot_done(bootDoneB)
  );

  wire [7:0]  obsRdata    = selB ? busB.rdata   : busA.rdata;
  wire        obsDataOe   = selB ? busB.data_oe : busA.data_oe;
  wire        obsReady    = selB ? busB.ready   : busA.ready;
  wire        obsRomEn    = selB ? romEnB       : romEnA;
  wire [7:0]  obsRomAddr  = selB ? romAddrB     : romAddrA;
  wire        obsWramEn   = selB ? wramEnB      : wramEnA;
  wire        obsWramWe   = selB ? wramWeB      : wramWeA;
  wire [12:0] obsWramAddr = selB ? wramAddrB    : wramAddrA;
  wire [7:0]  obsWramDin  = selB ? wramDinB     : wramDinA;
  wire        obsBootDone = selB ? bootDoneB    : bootDoneA;

  int checks = 0;
  int errors = 0;

`ifdef SM83_BOOT_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit b, input bit cs, input bit oe, input bit we,
                               input logic [15:0] a, input logic [7:0] d);
    selB     = b;
    reqCs    = cs;
    reqOe    = oe;
    reqWe    = we;
    reqAddr  = a;
    reqWdata = d;
  endtask

  task automatic readTxn(input bit b, input logic [15:0] a, input logic [7:0] expData,
                         input int expLat, input bit expRomEn, input bit expWramEn, input string tag);
    int  n;
    bit  seen;
    applyStimulus(b, 1'b1, 1'b1, 1'b0, a, 8'h00);
    @(posedge clk); #1;
    checkOutput({tag, "_rom_en"}, 32'(obsRomEn), 32'(expRomEn));
    checkOutput({tag, "_wram_en"}, 32'(obsWramEn), 32'(expWramEn));
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 8) begin
      if (obsReady) seen = 1'b1;
      else begin
        checkOutput({tag, "_oe_early"}, 32'(obsDataOe), 32'd0);
        n++;
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(expLat + 1));
    checkOutput({tag, "_data_oe"}, 32'(obsDataOe), 32'd1);
    checkOutput({tag, "_rdata"}, 32'(obsRdata), 32'(expData));
    applyStimulus(b, 1'b0, 1'b0, 1'b0, a, 8'h00);
    @(posedge clk); #1;
    checkOutput({tag, "_ready_drop"}, 32'(obsReady), 32'd0);
    checkOutput({tag, "_oe_drop"}, 32'(obsDataOe), 32'd0);
    checkOutput({tag, "_rdata_hold"}, 32'(obsRdata), 32'(expData));
  endtask

  task automatic writeTxn(input bit b, input logic [15:0] a, input logic [7:0] d, input bit oe,
                          input bit expWe, input logic [12:0] expAddr, input string tag);
    applyStimulus(b, 1'b1, oe, 1'b1, a, d);
    @(posedge clk); #1;
    checkOutput({tag, "_ready"}, 32'(obsReady), 32'd1);
    checkOutput({tag, "_data_oe"}, 32'(obsDataOe), 32'd0);
    checkOutput({tag, "_wram_we"}, 32'(obsWramWe), 32'(expWe));
    checkOutput({tag, "_wram_en"}, 32'(obsWramEn), 32'(expWe));
    checkOutput({tag, "_wram_addr"}, 32'(obsWramAddr), 32'(expAddr));
    checkOutput({tag, "_wram_din"}, 32'(obsWramDin), 32'(d));
    applyStimulus(b, 1'b0, 1'b0, 1'b0, a, 8'h00);
    @(posedge clk); #1;
    checkOutput({tag, "_ready_drop"}, 32'(obsReady), 32'd0);
    checkOutput({tag, "_we_drop"}, 32'(obsWramWe), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r1;
    int r2;
    for (int i = 0; i < 256; i++) romMem[i] = 8'(i) ^ 8'h5A;
    romMem[0] = 8'h31;
    romMem[5] = 8'hC3;
    for (int i = 0; i < 8192; i++) begin
      wramMemA[i] = 8'h00;
      wramMemB[i] = 8'h00;
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      selB = k[0];
      #1;
      checkOutput("rst_rdata", 32'(obsRdata), 32'd0);
      checkOutput("rst_data_oe", 32'(obsDataOe), 32'd0);
      checkOutput("rst_ready", 32'(obsReady), 32'd0);
      checkOutput("rst_rom_en", 32'(obsRomEn), 32'd0);
      checkOutput("rst_rom_addr", 32'(obsRomAddr), 32'd0);
      checkOutput("rst_wram_en", 32'(obsWramEn), 32'd0);
      checkOutput("rst_wram_we", 32'(obsWramWe), 32'd0);
      checkOutput("rst_wram_addr", 32'(obsWramAddr), 32'd0);
      checkOutput("rst_wram_din", 32'(obsWramDin), 32'd0);
      checkOutput("rst_boot_done", 32'(obsBootDone), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    readTxn(1'b0, 16'h0000, 8'h31, 1, 1'b1, 1'b0, "romA_0000");
    readTxn(1'b0, 16'h8000, 8'hFF, 1, 1'b0, 1'b0, "unmapA_8000");

    writeTxn(1'b1, 16'hC010, 8'hA5, 1'b0, 1'b1, 13'h0010, "wrB_C010");
    readTxn(1'b1, 16'hC010, 8'hA5, 2, 1'b0, 1'b1, "rdB_C010");
    readTxn(1'b1, 16'h8000, 8'hFF, 2, 1'b0, 1'b0, "unmapB_8000");

    writeTxn(1'b1, 16'hC000, 8'h5A, 1'b1, 1'b1, 13'h0000, "bothB_C000");
    readTxn(1'b1, 16'hC000, 8'h5A, 2, 1'b0, 1'b1, "rdB_C000");

    // Request held across two reads: ready pulses in cycles 3 and 7 with READ_LAT=2.
    r1 = 0;
    r2 = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'hC010, 8'h00);
    for (int c = 1; c <= 12 && r2 == 0; c++) begin
      @(posedge clk); #1;
      if (obsReady) begin
        if (r1 == 0) r1 = c;
        else         r2 = c;
      end
    end
    checkOutput("b2b_first_ready", 32'(r1), 32'd3);
    checkOutput("b2b_second_ready", 32'(r2), 32'd7);
    checkOutput("b2b_rdata", 32'(obsRdata), 32'hA5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (2) @(posedge clk);
    #1;

    readTxn(1'b1, 16'hFF50, OVL ? 8'hFE : 8'hFF, 2, 1'b0, 1'b0, "bootreg_rd0");
    writeTxn(1'b1, 16'hFF50, 8'h00, 1'b0, 1'b0, 13'h1F50, "bootreg_wr00");
    checkOutput("boot_done_after_00", 32'(obsBootDone), 32'd0);
    writeTxn(1'b1, 16'hFF50, 8'h01, 1'b0, 1'b0, 13'h1F50, "bootreg_wr01");
    checkOutput("boot_done_after_01", 32'(obsBootDone), 32'(OVL));
    readTxn(1'b1, 16'h0000, OVL ? 8'hFF : 8'h31, 2, !OVL, 1'b0, "romB_after_boot");
    readTxn(1'b1, 16'hFF50, 8'hFF, 2, 1'b0, 1'b0, "bootreg_rd1");

    // Reset during the write cycle must keep the RAM write from landing.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'hC020, 8'h77);
    @(posedge clk); #1;
    checkOutput("rstwr_we_before", 32'(obsWramWe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstwr_we_drop", 32'(obsWramWe), 32'd0);
    checkOutput("rstwr_ready_drop", 32'(obsReady), 32'd0);
    checkOutput("rstwr_boot_done", 32'(obsBootDone), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    readTxn(1'b1, 16'hC020, 8'h00, 2, 1'b0, 1'b1, "rstwr_readback");
    readTxn(1'b1, 16'h0000, 8'h31, 2, 1'b1, 1'b0, "romB_after_rst");

    // Reset during RD_WAIT drops the enable at once; the next read starts cleanly.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h00);
    @(posedge clk); #1;
    checkOutput("rstrd_rom_en_before", 32'(obsRomEn), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstrd_rom_en_drop", 32'(obsRomEn), 32'd0);
    checkOutput("rstrd_ready", 32'(obsReady), 32'd0);
    checkOutput("rstrd_data_oe", 32'(obsDataOe), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstrd_boot_done", 32'(obsBootDone), 32'd0);
    checkOutput("rstrd_ready_idle", 32'(obsReady), 32'd0);
    readTxn(1'b0, 16'h0005, 8'hC3, 1, 1'b1, 1'b0, "romA_0005");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm83_mem_ctrl.md
# sm83_mem_ctrl

Parametrised memory-side controller between the SM83 core's external bus and the on-chip synchronous block RAMs (boot ROM, work RAM). It replaces the purely combinational address decoder with registered region decode, a read-latency sequencer with a `ready` handshake, a write-strobe path into work RAM, and a sticky boot-ROM overlay disable register. It sits directly below `cpu_top` in the SoC top and drives the RAM IP ports. No tri-states inside: the data-bus driver is enabled by `data_oe`.

## Interface
- `ADDR_W`, 16, CPU address width
- `DATA_W`, 8, data width
- `ROM_BASE`, 16'h0000, boot ROM base address
- `ROM_AW`, 8, boot ROM address bits (256 B)
- `WRAM_BASE`, 16'hC000, work RAM base address
- `WRAM_AW`, 13, work RAM address bits (8 KiB)
- `READ_LAT`, 1, RAM read latency in cycles (1..3)
- `BOOT_DIS_ADDR`, 16'hFF50, overlay-disable register address
- `UNMAP_DATA`, 8'hFF, read value for unmapped addresses

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_cs`  in  1  CPU bus cycle request
- `mem_oe`  in  1  read request qualifier
- `mem_we`  in  1  write request qualifier
- `addr`  in  ADDR_W  CPU address
- `wdata`  in  DATA_W  CPU write data
- `rdata`  out  DATA_W  read data to bus driver
- `data_oe`  out  1  enable external data-bus driver
- `ready`  out  1  one-cycle transfer-complete pulse
- `rom_en`  out  1  boot ROM enable
- `rom_addr`  out  ROM_AW  boot ROM address
- `rom_dout`  in  DATA_W  boot ROM data
- `wram_en`  out  1  work RAM enable
- `wram_we`  out  1  work RAM write enable
- `wram_addr`  out  WRAM_AW  work RAM address
- `wram_din`  out  DATA_W  work RAM write data
- `wram_dout`  in  DATA_W  work RAM data
- `boot_done`  out  1  overlay disabled (sticky)

## Operation
- States: IDLE, RD_WAIT, RD_DONE, WR.
- IDLE: request = `mem_cs & (mem_oe | mem_we)`. On request, register `addr`, `wdata`, region (ROM / WRAM / BOOTREG / UNMAPPED). `mem_we` has priority when both qualifiers high.
- Region decode: ROM if `addr - ROM_BASE < 2**ROM_AW` and `boot_done==0`; WRAM if `addr - WRAM_BASE < 2**WRAM_AW`; BOOTREG if `addr == BOOT_DIS_ADDR`; else UNMAPPED. Offsets are the low ROM_AW/WRAM_AW bits of the subtraction.
- Read -> RD_WAIT: selected `*_en` high, latency counter runs READ_LAT cycles, then RD_DONE. UNMAPPED/BOOTREG reads assert no enable but take the same latency.
- RD_DONE: `rdata` = registered `rom_dout`/`wram_dout`/UNMAP_DATA (BOOTREG reads return `{7'b1111111, boot_done}`), `data_oe=1`, `ready=1`; next IDLE.
- Write -> WR: one cycle; WRAM: `wram_en=wram_we=1`, `wram_din=wdata`; BOOTREG: nonzero `wdata` sets `boot_done`; ROM/UNMAPPED: dropped. `ready=1` in WR; next IDLE.
- Requests outside IDLE ignored; CPU holds request until `ready`. A request still asserted in the IDLE cycle after `ready` starts a new transfer.
- `boot_done` cleared only by reset; once set, ROM addresses decode as UNMAPPED.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, `boot_done=0`, `rdata=0`, `data_oe=0`, `ready=0`, all `*_en`/`wram_we` 0, addresses/`wram_din` 0.
- Reset mid-transfer: all outputs drop immediately on `rst` low; no partial write completes.
- Read: request sampled at edge E0; `*_en` high cycles 1..READ_LAT; `ready`/`data_oe`/`rdata` valid in cycle READ_LAT+1 only. Throughput: one read per READ_LAT+2 cycles.
- Write: request at E0; `wram_we` and `ready` high in cycle 1 only. One write per 2 cycles.
- `rdata` holds last read value between transfers; `data_oe` high only in RD_DONE.
- All outputs registered; no combinational path from CPU inputs to outputs.

## Configuration
- `SM83_BOOT_OVERLAY_EN` defined: BOOTREG decode, `boot_done` register, ROM unmapping as above.
- Not defined: no BOOTREG region (BOOT_DIS_ADDR decodes UNMAPPED), ROM permanently mapped, `boot_done` tied 0.

## Test plan
- Reset then read 16'h0000 with READ_LAT=1, ROM[0]=8'h31 -> `rom_en` cycle 1, `ready`+`data_oe` cycle 2, `rdata=8'h31`.
- Write 8'hA5 to 16'hC010, read back with READ_LAT=2 -> `wram_we` one cycle at `wram_addr=13'h0010`; read `ready` in cycle 3, `rdata=8'hA5`.
- Read 16'h8000 -> no enables, `rdata=8'hFF`, `ready` after READ_LAT+1 cycles.
- (Macro on) write 8'h01 to 16'hFF50, read 16'h0000 -> `boot_done=1`, `rom_en` stays 0, `rdata=8'hFF`; read 16'hFF50 -> 8'hFF.
- `mem_oe` and `mem_we` both high at 16'hC000 -> write path taken, `ready` after 1 cycle, no `data_oe`.
- Assert `rst` low during RD_WAIT -> `rom_en`, `ready` low same cycle; after release, state IDLE, `boot_done=0`.
